// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the memory-stage sequencer: access sizes, FSM states, dbus request payload.
package mem_access_ctrl_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned STRB_W = XLEN / 8;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef enum logic [1:0] {MA_IDLE, MA_REQ, MA_WAIT, MA_DONE} mem_acc_state_t;

  typedef struct packed {
    logic [XLEN-1:0]   addr;
    msize_t            size;
    logic [STRB_W-1:0] strobe;
    logic [XLEN-1:0]   data;
  } dbus_req_t;

endpackage

// File: rtl/mem_access_ctrl_align.sv
// Combinational lane steering: misalignment check, store strobe/shift, load shift and extension.
module mem_access_ctrl_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [2:0]        i_offset,
  input  msize_t            i_size,
  input  logic              i_unsigned,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [XLEN-1:0]   i_rdata,
  output logic              o_misalign_c,
  output logic [STRB_W-1:0] o_strobe_c,
  output logic [XLEN-1:0]   o_wdata_c,
  output logic [XLEN-1:0]   o_rdata_c
);

  logic [5:0]        w_shift;
  logic [XLEN-1:0]   w_raw;
  logic [STRB_W-1:0] w_base;

  always_comb begin
    w_shift      = {i_offset, 3'b000};
    w_raw        = i_rdata >> w_shift;
    o_wdata_c    = i_wdata << w_shift;
    o_misalign_c = 1'b0;
    w_base       = 8'hFF;
    o_rdata_c    = w_raw;
    case (i_size)
      MSIZE1: begin
        w_base    = 8'h01;
        o_rdata_c = i_unsigned ? {56'd0, w_raw[7:0]} : {{56{w_raw[7]}}, w_raw[7:0]};
      end
      MSIZE2: begin
        o_misalign_c = i_offset[0];
        w_base       = 8'h03;
        o_rdata_c    = i_unsigned ? {48'd0, w_raw[15:0]} : {{48{w_raw[15]}}, w_raw[15:0]};
      end
      MSIZE4: begin
        o_misalign_c = |i_offset[1:0];
        w_base       = 8'h0F;
        o_rdata_c    = i_unsigned ? {32'd0, w_raw[31:0]} : {{32{w_raw[31]}}, w_raw[31:0]};
      end
      default: begin
        o_misalign_c = |i_offset;
        w_base       = 8'hFF;
        o_rdata_c    = w_raw;
      end
    endcase
    o_strobe_c = w_base << i_offset;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: one load/store per M-stage instruction onto the dbus, with pipeline
// stall, flush-drop handling and an optional data_ok watchdog.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  input  msize_t            msize,
  input  logic              mem_unsigned,
  input  logic              flush,
  output logic              stall,
  output logic              resp_valid,
  output logic [XLEN-1:0]   rdata,
  output logic              misaligned,
  output logic              bus_err,
  output logic              dreq_valid,
  output logic [XLEN-1:0]   dreq_addr,
  output msize_t            dreq_size,
  output logic [STRB_W-1:0] dreq_strobe,
  output logic [XLEN-1:0]   dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [XLEN-1:0]   dresp_data
);

  localparam int unsigned WDOG_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  mem_acc_state_t    r_state;
  dbus_req_t         r_req;
  logic              r_unsigned;
  logic              r_is_store;
  logic              r_drop;
  logic              r_dreq_valid;
  logic              r_resp_valid;
  logic [XLEN-1:0]   r_rdata;
  logic              r_bus_err;
  logic [WDOG_W-1:0] r_wdog;

  logic              w_idle;
  logic              w_is_mem;
  logic              w_access;
  logic              w_start;
  logic              w_done;
  logic              w_wdog_hit;
  logic [2:0]        w_sel_off;
  msize_t            w_sel_size;
  logic              w_sel_uns;
  logic              w_misalign_c;
  logic [STRB_W-1:0] w_strobe_c;
  logic [XLEN-1:0]   w_wdata_c;
  logic [XLEN-1:0]   w_rdata_c;

  // In IDLE the aligner looks at the live request; afterwards at the latched one.
  assign w_idle     = (r_state == MA_IDLE);
  assign w_sel_off  = w_idle ? addr[2:0] : r_req.addr[2:0];
  assign w_sel_size = w_idle ? msize : r_req.size;
  assign w_sel_uns  = w_idle ? mem_unsigned : r_unsigned;

  mem_access_ctrl_align u_align (
    .i_offset     (w_sel_off),
    .i_size       (w_sel_size),
    .i_unsigned   (w_sel_uns),
    .i_wdata      (wdata),
    .i_rdata      (dresp_data),
    .o_misalign_c (w_misalign_c),
    .o_strobe_c   (w_strobe_c),
    .o_wdata_c    (w_wdata_c),
    .o_rdata_c    (w_rdata_c)
  );

  assign w_is_mem   = req_valid & (memread | memwrite);
  assign w_access   = w_is_mem & ~w_misalign_c;
  assign w_start    = w_idle & w_access & ~flush;
  assign w_done     = dresp_data_ok & ((r_state == MA_WAIT) | dresp_addr_ok);
  assign w_wdog_hit = (TIMEOUT != 0) && (r_wdog == WDOG_W'(TIMEOUT - 1));

  // Stall and misaligned must act in the cycle the instruction is presented.
  assign stall      = reset & (w_start | (r_state == MA_REQ) | (r_state == MA_WAIT));
  assign misaligned = reset & w_idle & w_is_mem & w_misalign_c & ~flush;
  assign resp_valid = r_resp_valid & ~flush;

  assign rdata       = r_rdata;
  assign bus_err     = r_bus_err;
  assign dreq_valid  = r_dreq_valid;
  assign dreq_addr   = r_req.addr;
  assign dreq_size   = r_req.size;
  assign dreq_strobe = r_req.strobe;
  assign dreq_data   = r_req.data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= MA_IDLE;
      r_req        <= '0;
      r_unsigned   <= 1'b0;
      r_is_store   <= 1'b0;
      r_drop       <= 1'b0;
      r_dreq_valid <= 1'b0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_bus_err    <= 1'b0;
      r_wdog       <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_bus_err    <= 1'b0;
      case (r_state)
        MA_IDLE: begin
          r_wdog <= '0;
          if (w_start) begin
            r_state      <= MA_REQ;
            r_req.addr   <= addr;
            r_req.size   <= msize;
            r_req.strobe <= memwrite ? w_strobe_c : '0;
            r_req.data   <= w_wdata_c;
            r_unsigned   <= mem_unsigned;
            r_is_store   <= memwrite;
            r_drop       <= 1'b0;
            r_dreq_valid <= 1'b1;
          end
        end
        MA_REQ, MA_WAIT: begin
          r_wdog <= r_wdog + WDOG_W'(1);
          if (flush) r_drop <= 1'b1;
          if (dresp_addr_ok) r_dreq_valid <= 1'b0;
          if (w_done) begin
            r_wdog <= '0;
            r_drop <= 1'b0;
            if (r_drop | flush) begin
              r_state <= MA_IDLE;
            end else begin
              r_state      <= MA_DONE;
              r_resp_valid <= 1'b1;
              r_rdata      <= r_is_store ? '0 : w_rdata_c;
            end
          end else if (w_wdog_hit) begin
            r_state      <= MA_IDLE;
            r_bus_err    <= 1'b1;
            r_drop       <= 1'b0;
            r_dreq_valid <= 1'b0;
            r_wdog       <= '0;
          end else if ((r_state == MA_REQ) && dresp_addr_ok) begin
            r_state <= MA_WAIT;
            r_wdog  <= '0;
          end
        end
        default: begin
          r_state <= MA_IDLE;
          r_wdog  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table plus hand-written corner sequences.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, memread, memwrite, mem_unsigned, flush;
  logic [63:0] addr, wdata, dresp_data;
  msize_t      msize;
  logic        stall, resp_valid, misaligned, bus_err, dreq_valid;
  logic [63:0] rdata, dreq_addr, dreq_data;
  msize_t      dreq_size;
  logic [7:0]  dreq_strobe;
  logic        dresp_addr_ok, dresp_data_ok;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .memread(memread), .memwrite(memwrite),
    .addr(addr), .wdata(wdata), .msize(msize), .mem_unsigned(mem_unsigned), .flush(flush),
    .stall(stall), .resp_valid(resp_valid), .rdata(rdata), .misaligned(misaligned),
    .bus_err(bus_err), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    msize_t      size;
    logic        uns;
    logic [63:0] bus;
    logic [7:0]  strobe;
    logic [63:0] ddata;
    logic [63:0] rdata;
    int          a_dly;
    int          d_dly;
  } vec_t;

  localparam int NVEC = 11;
  vec_t        vecs[NVEC];
  vec_t        mis[3];
  logic [63:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          seen_dreq;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // One clock: sample at negedge (scoreboard), return 1 time unit after the next posedge.
  task automatic cyc();
    @(negedge clk);
    if (dreq_valid) seen_dreq++;
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_resp: got resp_valid with rdata %h, required no response", rdata);
      end else begin
        chk("sb_rdata", rdata, exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; memread = 1'b0; memwrite = 1'b0; flush = 1'b0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
  endtask

  task automatic drive_req(input vec_t v);
    req_valid = 1'b1; memread = v.rd; memwrite = v.wr; addr = v.addr;
    wdata = v.wdata; msize = v.size; mem_unsigned = v.uns;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"}, 64'(stall), 64'd0);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_rdata"}, rdata, 64'd0);
    chk({tag, "_misaligned"}, 64'(misaligned), 64'd0);
    chk({tag, "_bus_err"}, 64'(bus_err), 64'd0);
    chk({tag, "_dreq_valid"}, 64'(dreq_valid), 64'd0);
    chk({tag, "_dreq_addr"}, dreq_addr, 64'd0);
    chk({tag, "_dreq_size"}, 64'(dreq_size), 64'd0);
    chk({tag, "_dreq_strobe"}, 64'(dreq_strobe), 64'd0);
    chk({tag, "_dreq_data"}, dreq_data, 64'd0);
  endtask

  // Full transaction; flush_cyc < 0 means no flush, otherwise flush pulses in that cycle.
  task automatic run_txn(input vec_t v, input int flush_cyc, input string tag);
    int stall_cnt;
    bit drop;
    drop = (flush_cyc >= 0);
    stall_cnt = 0;
    for (int c = 0; c <= v.d_dly + 1; c++) begin
      dresp_addr_ok = (c == v.a_dly);
      dresp_data_ok = (c == v.d_dly);
      dresp_data    = v.bus;
      flush         = (c == flush_cyc);
      if (c == 0) begin
        drive_req(v);
        if (!drop) exp_q.push_back(v.rdata);
      end else if ((c == v.d_dly + 1) || (drop && c >= flush_cyc)) begin
        req_valid = 1'b0;
      end
      #1;
      if (c <= v.d_dly) stall_cnt += int'(stall);
      if (c == 1) begin
        chk({tag, "_dreq_valid"}, 64'(dreq_valid), 64'd1);
        chk({tag, "_dreq_addr"}, dreq_addr, v.addr);
        chk({tag, "_dreq_size"}, 64'(dreq_size), 64'(v.size));
        chk({tag, "_dreq_strobe"}, 64'(dreq_strobe), 64'(v.strobe));
        chk({tag, "_dreq_data"}, dreq_data, v.ddata);
      end
      if (c == v.d_dly + 1) begin
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'(!drop));
        chk({tag, "_stall_end"}, 64'(stall), 64'd0);
      end
      cyc();
    end
    chk({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(v.d_dly + 1));
    idle_inputs();
  endtask

  initial begin
    //          rd    wr    addr           wdata          size    uns   bus            strb   ddata          rdata          a d
    vecs[0]  = '{1'b1, 1'b0, 64'h80000008, 64'h0, MSIZE8, 1'b0, 64'h1122334455667788, 8'h00, 64'h0, 64'h1122334455667788, 1, 3};
    vecs[1]  = '{1'b1, 1'b0, 64'h80000005, 64'h0, MSIZE1, 1'b0, 64'h000080FF00000000, 8'h00, 64'h0, 64'hFFFFFFFFFFFFFF80, 1, 1};
    vecs[2]  = '{1'b1, 1'b0, 64'h80000005, 64'h0, MSIZE1, 1'b1, 64'h000080FF00000000, 8'h00, 64'h0, 64'h0000000000000080, 2, 2};
    vecs[3]  = '{1'b0, 1'b1, 64'h80000006, 64'hBEEF, MSIZE2, 1'b0, 64'hDEADDEADDEADDEAD, 8'hC0, 64'hBEEF000000000000, 64'h0, 1, 2};
    vecs[4]  = '{1'b1, 1'b0, 64'h80000002, 64'h0, MSIZE2, 1'b0, 64'h0123456789ABCDEF, 8'h00, 64'h0, 64'hFFFFFFFFFFFF89AB, 1, 1};
    vecs[5]  = '{1'b1, 1'b0, 64'h80000002, 64'h0, MSIZE2, 1'b1, 64'h0123456789ABCDEF, 8'h00, 64'h0, 64'h00000000000089AB, 3, 5};
    vecs[6]  = '{1'b1, 1'b0, 64'h80000004, 64'h0, MSIZE4, 1'b0, 64'h89ABCDEF01234567, 8'h00, 64'h0, 64'hFFFFFFFF89ABCDEF, 1, 4};
    vecs[7]  = '{1'b1, 1'b0, 64'h80000004, 64'h0, MSIZE4, 1'b1, 64'h89ABCDEF01234567, 8'h00, 64'h0, 64'h0000000089ABCDEF, 2, 3};
    vecs[8]  = '{1'b0, 1'b1, 64'h80000004, 64'hCAFEF00D, MSIZE4, 1'b0, 64'h0, 8'hF0, 64'hCAFEF00D00000000, 64'h0, 1, 1};
    vecs[9]  = '{1'b0, 1'b1, 64'h80000003, 64'h5A, MSIZE1, 1'b0, 64'h0, 8'h08, 64'h000000005A000000, 64'h0, 1, 2};
    vecs[10] = '{1'b0, 1'b1, 64'h80000000, 64'h0102030405060708, MSIZE8, 1'b0, 64'h0, 8'hFF, 64'h0102030405060708, 64'h0, 2, 4};
    mis[0]   = '{1'b1, 1'b0, 64'h80000002, 64'h0, MSIZE4, 1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 0, 0};
    mis[1]   = '{1'b0, 1'b1, 64'h80000001, 64'h1234, MSIZE2, 1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 0, 0};
    mis[2]   = '{1'b1, 1'b0, 64'h80000004, 64'h0, MSIZE8, 1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 0, 0};

    reset = 1'b0; addr = '0; wdata = '0; msize = MSIZE1; mem_unsigned = 1'b0; dresp_data = '0;
    seen_dreq = 0;
    idle_inputs();
    cyc(); cyc();
    check_all_zero("reset");
    reset = 1'b1;
    cyc();

    for (int i = 0; i < NVEC; i++) run_txn(vecs[i], -1, $sformatf("vec%0d", i));

    // Misaligned accesses: immediate pulse, no stall, no bus traffic.
    for (int i = 0; i < 3; i++) begin
      seen_dreq = 0;
      drive_req(mis[i]);
      #1;
      chk($sformatf("mis%0d_pulse", i), 64'(misaligned), 64'd1);
      chk($sformatf("mis%0d_stall", i), 64'(stall), 64'd0);
      cyc();
      idle_inputs();
      #1;
      chk($sformatf("mis%0d_pulse_end", i), 64'(misaligned), 64'd0);
      cyc(); cyc();
      chk($sformatf("mis%0d_no_dreq", i), 64'(seen_dreq), 64'd0);
    end

    // Non-memory instruction and flush in IDLE: neither starts a transaction.
    seen_dreq = 0;
    req_valid = 1'b1; memread = 1'b0; memwrite = 1'b0;
    #1;
    chk("nonmem_stall", 64'(stall), 64'd0);
    cyc();
    drive_req(vecs[0]);
    flush = 1'b1;
    #1;
    chk("flush_idle_stall", 64'(stall), 64'd0);
    cyc();
    idle_inputs();
    cyc(); cyc();
    chk("idle_no_dreq", 64'(seen_dreq), 64'd0);

    // Flush one cycle after addr_ok, then a normal load.
    run_txn('{1'b1, 1'b0, 64'h80000008, 64'h0, MSIZE8, 1'b0, 64'hAAAA5555AAAA5555, 8'h00, 64'h0, 64'h0, 1, 4}, 2, "flush_wait");
    run_txn(vecs[0], -1, "after_flush");
    // Flush while still in REQ (addr_ok late) and flush in DONE.
    run_txn('{1'b1, 1'b0, 64'h80000010, 64'h0, MSIZE8, 1'b0, 64'h1, 8'h00, 64'h0, 64'h0, 3, 3}, 1, "flush_req");
    run_txn(vecs[6], vecs[6].d_dly + 1, "flush_done");
    run_txn(vecs[1], -1, "after_flush_done");

    // Watchdog: no addr_ok/data_ok at all.
    begin
      int early_err;
      early_err = 0;
      drive_req(vecs[0]);
      #1;
      chk("wdog_accept_stall", 64'(stall), 64'd1);
      cyc();
      req_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
        #1;
        early_err += int'(bus_err) + int'(!stall);
        cyc();
      end
      chk("wdog_early", 64'(early_err), 64'd0);
      chk("wdog_bus_err", 64'(bus_err), 64'd1);
      chk("wdog_stall", 64'(stall), 64'd0);
      chk("wdog_dreq_valid", 64'(dreq_valid), 64'd0);
      cyc();
      chk("wdog_pulse_end", 64'(bus_err), 64'd0);
      idle_inputs();
    end
    run_txn(vecs[3], -1, "after_wdog");

    // Reset held low mid-WAIT, request still asserted.
    drive_req(vecs[0]);
    dresp_data = vecs[0].bus;
    cyc();
    dresp_addr_ok = 1'b1;
    cyc();
    dresp_addr_ok = 1'b0;
    #1;
    chk("rst_wait_stall_pre", 64'(stall), 64'd1);
    reset = 1'b0;
    cyc();
    check_all_zero("rst_wait");
    idle_inputs();
    reset = 1'b1;
    cyc();
    run_txn(vecs[0], -1, "after_reset");

    cyc(); cyc();
    chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
